// File: rtl/booth_pkg.sv
// Shared encodings for the Booth sequential multiplier: FSM states and the
// per-step recoding decision.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } op_e;

  // Radix-2 Booth recoding of the {Q[0], Q_-1} bit pair.
  function automatic op_e booth_op(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, Q_-1}.
module booth_step
  import booth_pkg::*;
#(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_q,
  input  logic         i_qm1,
  input  logic [N-1:0] i_m,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_q,
  output logic         o_qm1
);

  op_e          w_op;
  logic [N-1:0] w_sum;

  always_comb begin
    w_op  = booth_op(i_q[0], i_qm1);
    w_sum = i_a;
    case (w_op)
      OP_ADD:  w_sum = i_a + i_m;
      OP_SUB:  w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  assign o_a   = {w_sum[N-1], w_sum[N-1:1]};
  assign o_q   = {w_sum[0], i_q[N-1:1]};
  assign o_qm1 = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Parametrised radix-2 Booth sequential multiplier (signed or unsigned) with a
// start/done handshake; one iteration per clock over WIDTH+1 extended bits.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N  = WIDTH + 1;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [N-1:0]       r_a;
  logic [N-1:0]       r_q;
  logic               r_qm1;
  logic [N-1:0]       r_m;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_load;
  logic               w_iter;
  logic               w_last;
  logic [N-1:0]       w_a_nxt;
  logic [N-1:0]       w_q_nxt;
  logic               w_qm1_nxt;
  logic [2*N-1:0]     w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_iter = 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_last = w_iter && (r_cnt == LastCnt);

  booth_step #(
    .N(N)
  ) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_qm1(r_qm1),
    .i_m  (r_m),
    .o_a  (w_a_nxt),
    .o_q  (w_q_nxt),
    .o_qm1(w_qm1_nxt)
  );

  assign w_full = {w_a_nxt, w_q_nxt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      // Extra top bit keeps the most-negative multiplicand negatable.
      r_a   <= '0;
      r_q   <= {is_signed & multiplier[WIDTH-1], multiplier};
      r_m   <= {is_signed & multiplicand[WIDTH-1], multiplicand};
      r_qm1 <= 1'b0;
      r_cnt <= '0;
    end else if (w_iter) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_qm1 <= w_qm1_nxt;
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_product <= w_full[2*WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: 8-bit and 16-bit instances, directed
// vectors with hand-computed products and latency checks.
module tb_booth_mult_seq;

  typedef struct {
    logic [31:0] prod;
    int          sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        st8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  m8 = '0, q8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        st16 = 1'b0, sg16 = 1'b0;
  logic [15:0] m16 = '0, q16 = '0;
  logic        busy16, done16;
  logic [31:0] p16;

  exp_t sb8[$];
  exp_t sb16[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (st8),
    .is_signed   (sg8),
    .multiplicand(m8),
    .multiplier  (q8),
    .busy        (busy8),
    .done        (done8),
    .product     (p8)
  );

  booth_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .start       (st16),
    .is_signed   (sg16),
    .multiplicand(m16),
    .multiplier  (q16),
    .busy        (busy16),
    .done        (done16),
    .product     (p16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected result on each done pulse, check product and latency.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (sb8.size() == 0) begin
        chk("spurious_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        chk("product8", {16'h0, p8}, e.prod);
        chk("latency8", 32'(cyc - e.sc), 32'd9);
      end
    end
    if (!rst && done16) begin
      if (sb16.size() == 0) begin
        chk("spurious_done16", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb16.pop_front();
        chk("product16", p16, e.prod);
        chk("latency16", 32'(cyc - e.sc), 32'd17);
      end
    end
  end

  // Drive start for one edge; optionally record the expected product.
  task automatic issue8(input logic sgn, input logic [7:0] m, input logic [7:0] q,
                        input logic push, input logic [15:0] exp);
    st8 = 1'b1; sg8 = sgn; m8 = m; q8 = q;
    if (push) sb8.push_back('{prod: {16'h0, exp}, sc: cyc + 1});
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  task automatic issue16(input logic sgn, input logic [15:0] m, input logic [15:0] q,
                         input logic [31:0] exp);
    st16 = 1'b1; sg16 = sgn; m16 = m; q16 = q;
    sb16.push_back('{prod: exp, sc: cyc + 1});
    @(posedge clk); #1;
    st16 = 1'b0;
  endtask

  // Returns at the negedge where done8 is seen, or flags a timeout.
  task automatic wait_done8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 40);
    if (!done8) chk("timeout8", 32'd0, 32'd1);
  endtask

  task automatic wait_done16();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done16 && n < 60);
    if (!done16) chk("timeout16", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    int dc;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy8", {31'h0, busy8}, 32'd0);
    chk("rst_done8", {31'h0, done8}, 32'd0);
    chk("rst_prod8", {16'h0, p8}, 32'd0);
    chk("rst_prod16", p16, 32'd0);

    // 7 x -3, with busy/done window counted
    issue8(1'b1, 8'd7, 8'hFD, 1'b1, 16'hFFEB);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8) bc++;
      if (done8) dc++;
    end
    chk("busy_cycles8", 32'(bc), 32'd9);
    chk("done_pulses8", 32'(dc), 32'd1);
    @(posedge clk); #1;

    issue8(1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
    wait_done8(); @(posedge clk); #1;
    issue8(1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0001);
    wait_done8(); @(posedge clk); #1;
    issue8(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000);
    wait_done8(); @(posedge clk); #1;
    issue8(1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080);
    wait_done8(); @(posedge clk); #1;
    issue8(1'b1, 8'h00, 8'h80, 1'b1, 16'h0000);
    wait_done8(); @(posedge clk); #1;

    // start pulsed mid-RUN must be ignored
    issue8(1'b0, 8'd3, 8'd5, 1'b1, 16'h000F);
    repeat (2) @(posedge clk);
    #1;
    st8 = 1'b1; sg8 = 1'b1; m8 = 8'd10; q8 = 8'd10;
    @(posedge clk); #1;
    st8 = 1'b0;
    wait_done8();
    repeat (12) @(posedge clk);
    #1;

    // back-to-back: start held during the DONE cycle
    issue8(1'b1, 8'd2, 8'd3, 1'b1, 16'h0006);
    wait_done8();
    st8 = 1'b1; sg8 = 1'b1; m8 = 8'hFC; q8 = 8'd5;
    sb8.push_back('{prod: 32'h0000_FFEC, sc: cyc + 1});
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("b2b_busy8", {31'h0, busy8}, 32'd1);
    wait_done8(); @(posedge clk); #1;

    // reset at RUN count=4 discards the operation
    issue8(1'b0, 8'd9, 8'd9, 1'b0, 16'h0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy8", {31'h0, busy8}, 32'd0);
    chk("midrst_done8", {31'h0, done8}, 32'd0);
    chk("midrst_prod8", {16'h0, p8}, 32'd0);
    repeat (15) @(posedge clk);
    #1;

    // wider instance
    issue16(1'b1, 16'h8000, 16'hFFFF, 32'h0000_8000);
    wait_done16(); @(posedge clk); #1;
    issue16(1'b0, 16'hFFFF, 16'h0002, 32'h0001_FFFE);
    wait_done16(); @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;

    chk("drain8", 32'(sb8.size()), 32'd0);
    chk("drain16", 32'(sb16.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Self-contained, parametrised radix-2 Booth sequential multiplier: datapath and control FSM in one block, with start/done handshake.
- Generalises the fixed 8-bit signed Booth datapath to WIDTH bits, adds an unsigned mode, and adds an internal iteration counter.
- Sits between operand registers and the result display/bus logic, in place of the separate 8-bit datapath-plus-external-controller pair.

Parameters:
- WIDTH, 8, operand width in bits; legal values are 2..32.
- N (localparam), WIDTH+1, internal extended operand width and iteration count.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a multiply; sampled only in IDLE or DONE.
- is_signed, input, 1, 1 means two's-complement operands, 0 means unsigned; sampled with start.
- multiplicand, input, WIDTH, operand M; sampled with start.
- multiplier, input, WIDTH, operand Q; sampled with start.
- busy, output, 1, high while iterating (RUN state).
- done, output, 1, one-cycle pulse when product becomes valid.
- product, output, 2*WIDTH, result; holds until the next accepted start.

Behaviour:
- Reset: synchronous; applies on any clk edge with rst=1, including mid-RUN.
  - state=IDLE, busy=0, done=0, product=0.
  - Internal A, Q, Q_-1, M and count all 0.
  - Any in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> load, go to RUN; start=0 -> stay.
  - RUN: start is ignored; operands are not re-sampled.
    - count<N-1: stay in RUN, count+1.
    - count==N-1: go to DONE.
  - DONE: done=1 for this cycle only.
    - start=1 -> load, go to RUN (back-to-back, no idle gap).
    - start=0 -> go to IDLE.
- Load, at the edge that samples start:
  - Extend M and Q to N bits: sign-extend if is_signed=1, zero-extend otherwise.
  - A=0, Q_-1=0, count=0.
- Iteration, one per RUN edge; add/sub and shift happen in the same edge:
  - {Q[0],Q_-1}=10: A=A-M.
  - {Q[0],Q_-1}=01: A=A+M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift by 1 of {A,Q,Q_-1}, width 2N+1; the MSB of the new A is replicated.
  - All arithmetic is modulo 2^N. The N-bit extension guarantees no overflow, including multiplicand=most-negative WIDTH-bit value.
- Latency: with start sampled at edge E, iterations occur at edges E+1..E+N.
  - At edge E+N: product <= low 2*WIDTH bits of {A,Q}; done <= 1; busy <= 0.
  - WIDTH=8 gives done high 9 cycles after the start edge.
- busy is 1 exactly in RUN; done is 1 exactly in DONE. Both are registered outputs, no combinational paths from inputs.
- product changes only at a completion edge (and at reset). A new start does not clear product until that operation completes.

Decomposition:
- Package/include booth_pkg:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - booth op codes OP_NOP/OP_ADD/OP_SUB.
- One combinational sub-module, booth_step:
  - inputs A, Q, Q_-1, M, all width N;
  - outputs the next {A,Q,Q_-1} (add/sub + arithmetic shift).
  - Instantiated once; the FSM, counter and registers stay in booth_mult_seq.

Test Plan:
- WIDTH=8, signed 7 x -3 -> product=16'hFFEB; done pulses exactly 9 cycles after start edge; busy high for 9 cycles.
- WIDTH=8, unsigned 255 x 255 -> 16'hFE01. Same operands signed (-1 x -1) -> 16'h0001.
- WIDTH=8, signed corner cases:
  - -128 x -128 -> 16'h4000;
  - -128 x 127 -> 16'hC080;
  - 0 x -128 -> 16'h0000.
- Start abuse:
  - Pulse start again mid-RUN with different operands -> ignored; result is still the first operation's; one done only.
  - start held high in the DONE cycle -> second operation begins with no idle cycle; its done arrives 9 cycles later.
- Reset mid-op: rst=1 at RUN count=4 -> next cycle busy=0, done=0, product=0; no done pulse follows.
- Wider instance:
  - WIDTH=16, signed -32768 x -1 -> 32'h00008000, done after 17 cycles;
  - unsigned 65535 x 2 -> 32'h0001FFFE.
